// File: rtl/square_wave_meter_if.sv
// Square wave meter bus.
// Groups the measurement controls and results into one bundle.
//   ena           : measurement enable (master -> meter)
//   sig_in        : asynchronous square wave under measurement (master -> meter)
//   prescaler_out : last measured half-period, clk cycles between toggles minus 1
//   meas_valid    : one-cycle pulse when prescaler_out updates
//   locked        : high while the last two measurements are equal
//   timeout       : sticky flag, no edge seen within 2^WIDTH cycles
interface square_wave_meter_if #(
    parameter int WIDTH = 16
);
    logic             ena;
    logic             sig_in;
    logic [WIDTH-1:0] prescaler_out;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output ena,
        output sig_in,
        input  prescaler_out,
        input  meas_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  ena,
        input  sig_in,
        output prescaler_out,
        output meas_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/square_wave_meter.sv
// Square wave half-period meter.
// Synchronizes an asynchronous square wave, detects both edge polarities and
// counts clk cycles between successive edges. Each interval is reported as
// (cycles - 1) with a one-cycle valid pulse; equal consecutive results raise
// locked, and a missing edge for 2^WIDTH cycles raises a sticky timeout.
// Ports:
//   clk : rising-edge clock for all state
//   rst : asynchronous active-high reset
//   bus : square_wave_meter_if.slave (ena, sig_in in; results out)
//
// state   | meaning
// IDLE    | disabled or just enabled; counter cleared
// ARM     | waiting for the first edge to start an interval
// MEASURE | counting cycles since the last edge
module square_wave_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    square_wave_meter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   synced;
    logic                   sig_edge;

    state_t                 state;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       prev;
    logic                   prev_exists;
    logic [WIDTH-1:0]       prescaler_q;
    logic                   meas_valid_q;
    logic                   locked_q;
    logic                   timeout_q;

    // Synchronizer and history flop run independently of ena so that the
    // edge detector is already settled when a measurement is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            hist_q <= synced;
        end
    end

    assign synced   = sync_q[SYNC_STAGES-1];
    assign sig_edge = synced ^ hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prev         <= '0;
            prev_exists  <= 1'b0;
            prescaler_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (!bus.ena) begin
            // Disable wins over any coincident edge; the last result is kept.
            state        <= IDLE;
            cnt          <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            prev_exists  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= ARM;
                end
                ARM: begin
                    if (sig_edge) begin
                        cnt   <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the all-ones cycle is still a valid
                    // measurement, so the edge branch is tested first.
                    if (sig_edge) begin
                        prescaler_q  <= cnt;
                        meas_valid_q <= 1'b1;
                        locked_q     <= prev_exists && (cnt == prev);
                        prev         <= cnt;
                        prev_exists  <= 1'b1;
                        timeout_q    <= 1'b0;
                        cnt          <= '0;
                    end else if (cnt == {WIDTH{1'b1}}) begin
                        timeout_q   <= 1'b1;
                        locked_q    <= 1'b0;
                        prev_exists <= 1'b0;
                        cnt         <= '0;
                        state       <= ARM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.prescaler_out = prescaler_q;
    assign bus.meas_valid    = meas_valid_q;
    assign bus.locked        = locked_q;
    assign bus.timeout       = timeout_q;

endmodule
